// File: rtl/test_report_arbiter.sv
// test_report_arbiter: round-robin report scheduler with per-suite summary and trailer emission.
// Define TEST_REPORT_TIMESTAMP_EN to append a 16-bit acceptance timestamp to each case record.
module test_report_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_SUITES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*4-1:0] req_suite,
    input  logic [NUM_REQ*8-1:0] req_case,
    input  logic [NUM_REQ-1:0]   req_fail,
    input  logic                 finish,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 done
);
`ifdef TEST_REPORT_TIMESTAMP_EN
    localparam logic [2:0] CASE_LAST = 3'd3;
`else
    localparam logic [2:0] CASE_LAST = 3'd1;
`endif
    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = (NUM_SUITES > 1) ? $clog2(NUM_SUITES) : 1;

    typedef enum logic [2:0] {IDLE, CASE, SUM, TRAIL, DONE} state_t;
    state_t state;
    logic [PW-1:0] rr_ptr, win;
    logic found, grant, finish_pend, last_suite;
    logic [SW-1:0] si;
    logic [2:0] bi, nb;
    logic [7:0] cap_case, case_nxt, sum_nxt;
    logic [3:0] sel_suite, fsuite;
    logic [15:0] tests [NUM_SUITES];
    logic [15:0] fails [NUM_SUITES];
`ifdef TEST_REPORT_TIMESTAMP_EN
    logic [15:0] ts, cap_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else ts <= ts + 16'd1;
    end
`endif

    always_comb begin
        int j;
        win = '0;
        found = 1'b0;
        j = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win = PW'(j);
            end
        end
        sel_suite = req_suite[win*4 +: 4];
        fsuite = (int'(sel_suite) >= NUM_SUITES) ? 4'(NUM_SUITES - 1) : sel_suite;
        grant = !rst && state == IDLE && !finish_pend && !finish && found;
        req_ready = grant ? (NUM_REQ'(1) << win) : '0;
        last_suite = si == SW'(NUM_SUITES - 1);
        nb = bi + 3'd1;
`ifdef TEST_REPORT_TIMESTAMP_EN
        case_nxt = nb == 3'd1 ? cap_case : nb == 3'd2 ? cap_ts[15:8] : cap_ts[7:0];
`else
        case_nxt = cap_case;
`endif
        sum_nxt = nb == 3'd1 ? tests[si][15:8] : nb == 3'd2 ? tests[si][7:0] :
                  nb == 3'd3 ? fails[si][15:8] : fails[si][7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            finish_pend <= 1'b0;
            out_valid <= 1'b0;
            out_data <= 8'h00;
            out_last <= 1'b0;
            done <= 1'b0;
            bi <= '0;
            si <= '0;
            cap_case <= '0;
`ifdef TEST_REPORT_TIMESTAMP_EN
            cap_ts <= '0;
`endif
            for (int i = 0; i < NUM_SUITES; i++) begin
                tests[i] <= '0;
                fails[i] <= '0;
            end
        end else begin
            if (finish && state != DONE) finish_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (finish_pend || finish) begin
                        state <= SUM;
                        si <= '0;
                    end else if (grant) begin
                        state <= CASE;
                        rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                        cap_case <= req_case[win*8 +: 8];
`ifdef TEST_REPORT_TIMESTAMP_EN
                        cap_ts <= ts;
`endif
                        out_valid <= 1'b1;
                        out_data <= {2'b10, req_fail[win], 1'b0, fsuite};
                        bi <= '0;
                        tests[fsuite[SW-1:0]] <= tests[fsuite[SW-1:0]] + 16'(tests[fsuite[SW-1:0]] != 16'hFFFF);
                        if (req_fail[win])
                            fails[fsuite[SW-1:0]] <= fails[fsuite[SW-1:0]] + 16'(fails[fsuite[SW-1:0]] != 16'hFFFF);
                    end
                end
                CASE: begin
                    if (out_ready) begin
                        if (bi == CASE_LAST) begin
                            out_valid <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bi <= nb;
                            out_data <= case_nxt;
                        end
                    end
                end
                SUM: begin
                    // Each suite gets one evaluation cycle while out_valid is low; empty ones advance there.
                    if (!out_valid || (out_ready && bi == 3'd4)) begin
                        if (!out_valid && tests[si] != 16'd0) begin
                            out_valid <= 1'b1;
                            out_data <= {4'b1100, 4'(si)};
                            bi <= '0;
                        end else if (last_suite) begin
                            state <= TRAIL;
                            out_valid <= 1'b1;
                            out_data <= 8'hFF;
                            out_last <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            si <= si + SW'(1);
                        end
                    end else if (out_ready) begin
                        bi <= nb;
                        out_data <= sum_nxt;
                    end
                end
                TRAIL: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_test_report_arbiter.sv
// tb_test_report_arbiter: directed + randomized bench; expected byte stream built from a
// queue-based model of grants, per-suite counts and the summary format.
`timescale 1ns/1ps
module tb_test_report_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_valid = '0, req_fail = '0, req_ready;
    logic [15:0] req_suite = '0;
    logic [31:0] req_case = '0;
    logic finish = 1'b0, out_ready = 1'b1, out_valid, out_last, done;
    logic [7:0] out_data;
    int n_cmp = 0, n_bad = 0;
    int m_tests[4], m_fails[4];
    int m_rr = 0;
    logic [8:0] exp_q[$], got_q[$];
    logic [15:0] cyc;
    logic hold_v = 1'b0;
    logic [8:0] hold_d;

    test_report_arbiter #(.NUM_REQ(4), .NUM_SUITES(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_suite(req_suite), .req_case(req_case), .req_fail(req_fail),
        .finish(finish), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) cyc <= rst ? 16'd0 : cyc + 16'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Grant model: round-robin from the model pointer; each grant appends its record to exp_q.
    always @(negedge clk) begin
        int w, s;
        w = -1;
        s = 0;
        if (!rst && |(req_valid & req_ready)) begin
            for (int k = 0; k < 4; k++)
                if (w < 0 && req_valid[(m_rr + k) % 4]) w = (m_rr + k) % 4;
            check("grant", 32'(req_ready), 32'(1) << w);
            m_rr = (w + 1) % 4;
            s = int'(req_suite[w*4 +: 4]);
            if (s > 3) s = 3;
            exp_q.push_back({1'b0, 2'b10, req_fail[w], 1'b0, 4'(s)});
            exp_q.push_back({1'b0, req_case[w*8 +: 8]});
`ifdef TEST_REPORT_TIMESTAMP_EN
            exp_q.push_back({1'b0, cyc[15:8]});
            exp_q.push_back({1'b0, cyc[7:0]});
`endif
            m_tests[s]++;
            if (req_fail[w]) m_fails[s]++;
        end
    end

    always @(negedge clk) begin
        if (rst) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'({out_last, out_data}), 32'(hold_d));
            end
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            hold_v = out_valid && !out_ready;
            hold_d = {out_last, out_data};
        end
    end

    task automatic push_summary();
        int t, f;
        for (int s = 0; s < 4; s++) if (m_tests[s] != 0) begin
            t = m_tests[s] > 65535 ? 65535 : m_tests[s];
            f = m_fails[s] > 65535 ? 65535 : m_fails[s];
            exp_q.push_back({1'b0, 4'hC, 4'(s)});
            exp_q.push_back({1'b0, 8'(t >> 8)});
            exp_q.push_back({1'b0, 8'(t)});
            exp_q.push_back({1'b0, 8'(f >> 8)});
            exp_q.push_back({1'b0, 8'(f)});
        end
        exp_q.push_back(9'h1FF);
    endtask

    task automatic compare_stream(input string tag);
        for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1 check("rst_async_valid", 32'(out_valid), 0);
        m_tests = '{default: 0};
        m_fails = '{default: 0};
        m_rr = 0;
        got_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int p, input logic [3:0] s, input logic [7:0] c, input logic f);
        req_valid[p] = 1'b1;
        req_suite[p*4 +: 4] = s;
        req_case[p*8 +: 8] = c;
        req_fail[p] = f;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[p]) break;
        end
        check("send_grant", 32'(req_ready[p]), 1);
        @(posedge clk);
        #1 req_valid[p] = 1'b0;
    endtask

    task automatic rand_fields(input int max_suite);
        for (int p = 0; p < 4; p++) begin
            req_suite[p*4 +: 4] = 4'($urandom_range(max_suite));
            req_case[p*8 +: 8] = 8'($urandom);
            req_fail[p] = 1'($urandom);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("done", 32'(done), 1);
    endtask

    initial begin
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b0;

        send(2, 4'd1, 8'h05, 1'b0);
        repeat (4) @(negedge clk);
        check("single_n", 32'(got_q.size()), 2);
        if (got_q.size() == 2) begin
            check("single_b0", 32'(got_q[0]), 'h081);
            check("single_b1", 32'(got_q[1]), 'h005);
        end
        compare_stream("single");

        @(posedge clk);
        #1 req_valid = 4'hF;
        for (int i = 0; i < 30; i++) begin
            rand_fields(3);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        compare_stream("round_robin");

        for (int i = 0; i < 400; i++) begin
            rand_fields(7);
            req_valid = 4'($urandom);
            out_ready = $urandom_range(9) < 7;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        out_ready = 1'b1;
        compare_stream("random");

        send(1, 4'd3, 8'hA5, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_valid", 32'(out_valid), 1);
        check("bp_data", 32'(out_data), 'hA5);
        @(posedge clk);
        #1 out_ready = 1'b1;
        compare_stream("backpressure");

        do_reset();
        send(0, 4'd0, 8'h10, 1'b0);
        send(1, 4'd0, 8'h11, 1'b0);
        send(3, 4'd0, 8'h12, 1'b0);
        send(2, 4'd2, 8'h20, 1'b1);
        send(0, 4'd2, 8'h21, 1'b1);
        compare_stream("pre_finish");
        req_valid[0] = 1'b1;
        finish = 1'b1;
        @(negedge clk);
        check("finish_wins", 32'(req_ready), 0);
        @(posedge clk);
        #1 finish = 1'b0;
        push_summary();
        check("summary_model_len", 32'(exp_q.size()), 11);
        @(negedge clk);
        check("sum_no_grant", 32'(req_ready), 0);
        wait_done();
        compare_stream("summary");
        @(posedge clk);
        #1 finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        repeat (5) @(negedge clk);
        check("done_hold", 32'(done), 1);
        check("done_quiet", 32'(out_valid), 0);
        check("done_no_grant", 32'(req_ready), 0);
        req_valid = '0;

        do_reset();
        @(negedge clk);
        check("rst_done_clear", 32'(done), 0);
        @(posedge clk);
        #1;
        send(1, 4'd2, 8'h3C, 1'b1);
        finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("sum_hdr", 32'({out_valid, out_data}), 'h1C2);
        compare_stream("finish_in_case");
        @(posedge clk);
        #2 do_reset();
        out_ready = 1'b1;
        send(3, 4'd0, 8'h77, 1'b0);
        compare_stream("post_reset_case");
        finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        push_summary();
        wait_done();
        compare_stream("post_reset_summary");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
